// File: rtl/instruction_encoder_if.sv
// Field-bundle handshake plus instruction-memory write bus for the
// instruction encoder.
//   in_valid/in_ready : bundle handshake (producer -> encoder)
//   fmt..imm          : RV32 fields of the bundle
//   mem_we/mem_addr/mem_wdata/mem_ack : word write toward program memory
// slave  = encoder side, master = bundle producer / memory model side.
interface instruction_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        fmt;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [2:0]        funct3;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [6:0]        funct7;
  logic [11:0]       imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;

  modport slave (
    input  in_valid, fmt, opcode, rd, funct3, rs1, rs2, funct7, imm, mem_ack,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, fmt, opcode, rd, funct3, rs1, rs2, funct7, imm, mem_ack,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instruction_encoder.sv
// Packs RV32 R/I/S field bundles into 32-bit words and writes them to
// consecutive instruction-memory word addresses starting at BASE_ADDR.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clear    : synchronous restart of fill pointer and error flag
//   b        : bundle handshake + memory write bus (slave side)
//   count    : words written since reset/clear (0..2^ADDR_W)
//   full     : every location has been written
//   err      : sticky, an fmt=3 bundle was accepted
// All outputs come straight from flops.
module instruction_encoder #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  instruction_encoder_if.slave b,
  output logic [ADDR_W:0]      count,
  output logic                 full,
  output logic                 err
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FULL} state_t;

  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

  state_t            state, state_nx;
  logic [ADDR_W:0]   count_nx;
  logic              err_nx;
  logic              load;
  logic              accept;
  logic [31:0]       packed_w;
  logic              rdy_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  // in_ready is a flop that is only ever 1 while state is IDLE, so the
  // handshake needs no extra state qualification.
  assign accept = b.in_valid & rdy_q;

  always_comb begin
    packed_w = '0;
    unique case (b.fmt)
      2'd0: packed_w = {b.funct7, b.rs2, b.rs1, b.funct3, b.rd, b.opcode};
      2'd1: packed_w = {b.imm, b.rs1, b.funct3, b.rd, b.opcode};
      2'd2: packed_w = {b.imm[11:5], b.rs2, b.rs1, b.funct3, b.imm[4:0], b.opcode};
      default: packed_w = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    err_nx   = err;
    load     = 1'b0;
    if (clear) begin
      // aborts a pending write and drops a same-cycle handshake
      state_nx = S_IDLE;
      count_nx = '0;
      err_nx   = 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            if (b.fmt == 2'd3) begin
              err_nx = 1'b1;
            end else begin
              state_nx = S_WRITE;
              load     = 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (b.mem_ack) begin
            count_nx = count + 1'b1;
            state_nx = (count_nx == CAP) ? S_FULL : S_IDLE;
          end
        end
        S_FULL: ;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      count   <= '0;
      err     <= 1'b0;
      full    <= 1'b0;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
    end else begin
      state  <= state_nx;
      count  <= count_nx;
      err    <= err_nx;
      full   <= (state_nx == S_FULL);
      rdy_q  <= (state_nx == S_IDLE);
      we_q   <= (state_nx == S_WRITE);
      // next address tracks the count; wraps back to BASE_ADDR when full,
      // but nothing is written there until clear restarts the fill
      addr_q <= BASE_ADDR + count_nx[ADDR_W-1:0];
      if (load) wdata_q <= packed_w;
    end
  end

  assign b.in_ready  = rdy_q;
  assign b.mem_we    = we_q;
  assign b.mem_addr  = addr_q;
  assign b.mem_wdata = wdata_q;

endmodule

// File: tb/tb_instruction_encoder.sv
module tb_instruction_encoder;
  localparam int         AW   = 2;
  localparam logic [1:0] BASE = 2'd1;
  localparam int         CAPN = 4;

  typedef struct {
    logic [1:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [11:0] imm;
  } fields_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } exp_t;

  logic clk, rst, clear;
  logic [AW:0] count;
  logic full, err;

  instruction_encoder_if #(.ADDR_W(AW)) bus();

  instruction_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .clear(clear), .b(bus),
    .count(count), .full(full), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sbq[$];
  int   m_count = 0;
  logic m_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack_ref(input fields_t f);
    logic [31:0] w;
    case (f.fmt)
      2'd0:    w = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
      2'd1:    w = {f.imm, f.rs1, f.funct3, f.rd, f.opcode};
      2'd2:    w = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic fields_t rnd_fields();
    fields_t f;
    f.fmt    = 2'($urandom_range(0, 2));
    f.opcode = 7'($urandom);
    f.rd     = 5'($urandom);
    f.funct3 = 3'($urandom);
    f.rs1    = 5'($urandom);
    f.rs2    = 5'($urandom);
    f.funct7 = 7'($urandom);
    f.imm    = 12'($urandom);
    return f;
  endfunction

  // Scoreboard: pops an expected word on the first mem_we cycle of each
  // write, then checks the bus stays frozen until the write drops.
  logic busy = 1'b0;
  exp_t cur;
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (!busy) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected_write", 32'(bus.mem_addr), 32'hFFFF_FFFF);
        end else begin
          cur = sbq.pop_front();
          chk("wr_addr", 32'(bus.mem_addr), 32'(cur.a));
          chk("wr_data", bus.mem_wdata, cur.d);
        end
        busy = 1'b1;
      end else begin
        chk("hold_addr", 32'(bus.mem_addr), 32'(cur.a));
        chk("hold_data", bus.mem_wdata, cur.d);
      end
      chk("rdy_in_write", 32'(bus.in_ready), 32'd0);
    end else begin
      busy = 1'b0;
    end
  end

  task automatic drive_fields(input fields_t f);
    bus.fmt = f.fmt; bus.opcode = f.opcode; bus.rd = f.rd; bus.funct3 = f.funct3;
    bus.rs1 = f.rs1; bus.rs2 = f.rs2; bus.funct7 = f.funct7; bus.imm = f.imm;
  endtask

  task automatic check_idle_after_restart(input string tag);
    chk({tag, "_we"}, 32'(bus.mem_we), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_addr"}, 32'(bus.mem_addr), 32'(BASE));
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // abort: 0 = complete normally, 1 = clear mid-write, 2 = rst mid-write
  task automatic put(input fields_t f, input logic [31:0] exp_w, input int dly, input int abort);
    int t = 0;
    exp_t e;
    while (bus.in_ready !== 1'b1 && t < 40) begin
      @(posedge clk); #1; t++;
    end
    if (bus.in_ready !== 1'b1) begin
      chk("rdy_timeout", 32'(bus.in_ready), 32'd1);
      return;
    end
    drive_fields(f);
    bus.in_valid = 1'b1;
    if (f.fmt != 2'd3) begin
      e.a = 2'(BASE + 2'(m_count));
      e.d = exp_w;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (f.fmt == 2'd3) begin
      m_err = 1'b1;
      chk("ill_err", 32'(err), 32'(m_err));
      chk("ill_we", 32'(bus.mem_we), 32'd0);
      chk("ill_count", 32'(count), 32'(m_count));
      chk("ill_rdy", 32'(bus.in_ready), 32'd1);
      return;
    end
    chk("lat_we", 32'(bus.mem_we), 32'd1);
    if (abort != 0) begin
      if (abort == 1) clear = 1'b1; else rst = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0; rst = 1'b0;
      m_count = 0; m_err = 1'b0;
      check_idle_after_restart(abort == 1 ? "abort_clr" : "abort_rst");
      if (abort == 2) begin
        chk("abort_rst_rdy0", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
      end
      chk("abort_rdy", 32'(bus.in_ready), 32'd1);
      return;
    end
    repeat (dly) begin
      @(posedge clk); #1;
    end
    chk("pre_ack_count", 32'(count), 32'(m_count));
    bus.mem_ack = 1'b1;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    m_count++;
    chk("count", 32'(count), 32'(m_count));
    chk("full", 32'(full), 32'(m_count == CAPN));
    chk("we_drop", 32'(bus.mem_we), 32'd0);
    chk("rdy_back", 32'(bus.in_ready), 32'(m_count != CAPN));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    m_count = 0; m_err = 1'b0;
  endtask

  fields_t f;

  initial begin
    rst = 1'b1; clear = 1'b0;
    bus.in_valid = 1'b0; bus.mem_ack = 1'b0;
    f = rnd_fields();
    drive_fields(f);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", 32'(bus.in_ready), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'(BASE));
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_rdy", 32'(bus.in_ready), 32'd1);

    // add x3,x1,x2 / addi x5,x0,-1 / sw x2,8(x1)
    f = '{2'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 12'h000};
    put(f, 32'h002081B3, 0, 0);
    f = '{2'd1, 7'h13, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 12'hFFF};
    put(f, 32'hFFF00293, 0, 0);
    f = '{2'd2, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 12'd8};
    put(f, 32'h0020A423, 0, 0);

    // delayed ack on the last free location
    f = rnd_fields();
    put(f, pack_ref(f), 5, 0);
    chk("full_rdy", 32'(bus.in_ready), 32'd0);

    // a bundle offered while full is ignored
    f = rnd_fields();
    drive_fields(f);
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("full_ignore_count", 32'(count), 32'(CAPN));
    chk("full_ignore_we", 32'(bus.mem_we), 32'd0);
    do_clear();
    check_idle_after_restart("clr_full");
    chk("clr_full_rdy", 32'(bus.in_ready), 32'd1);

    // illegal format, then a legal word still goes through
    f = rnd_fields();
    f.fmt = 2'd3;
    put(f, 32'd0, 0, 0);
    f = rnd_fields();
    put(f, pack_ref(f), 1, 0);
    chk("err_sticky", 32'(err), 32'd1);
    do_clear();
    chk("clr_err", 32'(err), 32'd0);

    // handshake coincident with clear is dropped
    f = rnd_fields();
    drive_fields(f);
    bus.in_valid = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; clear = 1'b0;
    chk("clr_drop_we", 32'(bus.mem_we), 32'd0);
    chk("clr_drop_count", 32'(count), 32'd0);

    // aborts mid-write, then a fresh write lands at BASE
    f = rnd_fields();
    put(f, pack_ref(f), 0, 1);
    f = rnd_fields();
    put(f, pack_ref(f), 0, 2);
    f = rnd_fields();
    put(f, pack_ref(f), 2, 0);

    for (int i = 0; i < 10; i++) begin
      if (m_count == CAPN) begin
        do_clear();
        chk("rnd_clr_count", 32'(count), 32'd0);
      end
      f = rnd_fields();
      put(f, pack_ref(f), int'($urandom_range(0, 3)), 0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Assembles RV32 instruction fields (opcode, rd, funct3, rs1, rs2, funct7, 12-bit immediate) into 32-bit instruction words and writes them sequentially into instruction memory through a write handshake. It is the loader-side counterpart of the field decode in the fetch/decode path: testbenches and the boot loader use it to fill program memory, and a word it writes decodes back to the same fields. Supports R-, I- and S-type packing, tracks the fill level and reports illegal formats.

## Interface
- ADDR_W, 8, instruction-memory word-address width; capacity 2^ADDR_W words
- BASE_ADDR, 0, first word address written after reset/clear
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- fmt  in  2  0=R, 1=I, 2=S, 3=illegal
- opcode  in  7  instruction[6:0]
- rd  in  5  destination register
- funct3  in  3  function code
- rs1  in  5  source register 1
- rs2  in  5  source register 2
- funct7  in  7  function code (R only)
- imm  in  12  immediate (I/S only)
- clear  in  1  synchronous restart of the fill pointer
- mem_we  out  1  write request, held until acknowledged
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded instruction
- mem_ack  in  1  memory accepted the write this cycle
- count  out  ADDR_W+1  words written since reset/clear
- full  out  1  count == 2^ADDR_W
- err  out  1  sticky illegal-format flag

## Operation
- Packing:
  - R = {funct7, rs2, rs1, funct3, rd, opcode}
  - I = {imm[11:0], rs1, funct3, rd, opcode}
  - S = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - Fields not used by a format are ignored.
- FSM states: IDLE, WRITE, FULL.
  - IDLE: in_ready=1. A handshake (in_valid & in_ready) with fmt 0–2 registers the packed word and moves to WRITE. A handshake with fmt=3 sets err, writes nothing and stays in IDLE.
  - WRITE: in_ready=0, mem_we=1. mem_addr and mem_wdata are stable until mem_ack. On mem_ack, count increments; go to FULL if the new count equals 2^ADDR_W, else IDLE.
  - FULL: in_ready=0, mem_we=0, full=1. Leave only on clear or rst.
- mem_addr = (BASE_ADDR + count) mod 2^ADDR_W, registered. After the last location it wraps only through clear.
- clear (any state): next state IDLE, count=0, mem_we=0, err=0. A write pending in WRITE is aborted and not counted. A handshake in the same cycle as clear is dropped.
- rst has priority over clear and has the same effect.
- mem_ack outside WRITE is ignored.

## Timing
- Reset values: in_ready=0 during the rst cycle, 1 from the first cycle after; mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, full=0, err=0.
- Latency: a handshake at edge N gives mem_we=1 with valid data/addr in cycle N+1.
- Throughput: at most one word per 2 cycles. With mem_ack in the first WRITE cycle, in_ready returns 1 in the following cycle.
- count, full and mem_addr update on the same edge that samples mem_ack.
- err asserts the cycle after an illegal handshake and stays set until rst or clear.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- R-type add x3,x1,x2 (opcode 0x33, rd 3, funct3 0, rs1 1, rs2 2, funct7 0), mem_ack immediate -> mem_wdata 0x002081B3 at mem_addr BASE_ADDR; count 1; in_ready high again 2 cycles after the handshake.
- I-type addi x5,x0,-1 (opcode 0x13, rd 5, imm 0xFFF) -> 0xFFF00293. S-type sw x2,8(x1) (opcode 0x23, funct3 2, rs1 1, rs2 2, imm 8) -> 0x0020A423 at the next address.
- mem_ack delayed 5 cycles -> mem_we, mem_addr and mem_wdata held constant for all 5 cycles, in_ready=0 throughout, count increments exactly once.
- ADDR_W=2: four writes -> addresses 0,1,2,3, count 4, full=1, in_ready=0. A fifth in_valid is ignored. clear -> count 0, mem_addr 0, accepts again.
- fmt=3 bundle -> no mem_we, err=1, count unchanged. A subsequent legal bundle is still written. clear -> err=0.
- clear, then separately rst, asserted during WRITE before mem_ack -> mem_we=0 next cycle, count=0, state IDLE, the aborted word is never counted.
